// File: rtl/sram_like_mem_slave.sv
// Single-outstanding sram-like responder backed by an inferred block RAM with fixed response latency.
// Optional feature: define SRAM_LIKE_BYTE_WRITE_EN for byte/halfword write lane enables.
module sram_like_mem_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic                  accept;
    logic                  rd_en;
    logic                  mem_we;
    logic [3:0]            lane_we;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  unused_bits;

    assign addr_ok = req && (state_q == IDLE);
    assign data_ok = (state_q == RESP);
    assign rdata   = rdata_q;
    assign accept  = addr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = wr;
                    size_d  = size;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // With LATENCY = 1 the read happens on the accepting edge, before addr_q is loaded.
    assign rd_idx = (state_q == IDLE) ? addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
    assign wr_idx = addr_q[ADDR_WIDTH+1:2];
    assign rd_en  = ((state_q == IDLE) && accept && !wr && (LATENCY == 1)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0) && !wr_q);
    assign mem_we = (state_q == RESP) && wr_q && !rst;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
`ifdef SRAM_LIKE_BYTE_WRITE_EN
        assign lane_we[gi] = (size_q == 2'd0) ? (addr_q[1:0] == 2'(gi)) :
                             (size_q == 2'd1) ? (addr_q[1] == 1'(gi / 2)) :
                                                1'b1;
`else
        assign lane_we[gi] = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Memory contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign unused_bits = ^{addr_q[31:ADDR_WIDTH+2], addr_q[1:0], size_q,
                           addr[31:ADDR_WIDTH+2], addr[1:0]};

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed bench for sram_like_mem_slave: a LATENCY=3 instance and a LATENCY=1 instance.
module tb_sram_like_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v   [2];
    logic        wr_v    [2];
    logic [1:0]  size_v  [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];

    logic [31:0] rdata_a, rdata_b;
    logic        addr_ok_a, addr_ok_b;
    logic        data_ok_a, data_ok_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_like_mem_slave #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_a),
        .addr_ok(addr_ok_a), .data_ok(data_ok_a)
    );

    sram_like_mem_slave #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_b),
        .addr_ok(addr_ok_b), .data_ok(data_ok_b)
    );

    function automatic logic get_aok(input int sel);
        return (sel != 0) ? addr_ok_b : addr_ok_a;
    endfunction

    function automatic logic get_dok(input int sel);
        return (sel != 0) ? data_ok_b : data_ok_a;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel != 0) ? rdata_b : rdata_a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller sits just after a negedge in an IDLE cycle; returns at the negedge of the RESP cycle.
    // The request stays asserted with junk fields while busy, so they must be ignored.
    task automatic txn(input int sel, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        int lat;
        int lat_exp;
        lat_exp = (sel != 0) ? 1 : 3;
        req_v[sel] = 1'b1; wr_v[sel] = w; size_v[sel] = sz; addr_v[sel] = a; wdata_v[sel] = wd;
        #1;
        check("addr_ok_idle", 32'(get_aok(sel)), 32'd1);
        @(posedge clk);
        #1;
        wr_v[sel] = ~w; size_v[sel] = 2'd3; addr_v[sel] = 32'hFFFF_FFFC; wdata_v[sel] = 32'h0BAD_BAD0;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("addr_ok_busy", 32'(get_aok(sel)), 32'd0);
            if (get_dok(sel)) begin
                lat = i;
                rd  = get_rdata(sel);
                break;
            end
        end
        req_v[sel] = 1'b0;
        check("latency", 32'(lat), 32'(lat_exp));
        $display("[TB] dut%0d %s size=%0d addr=%h wdata=%h rdata=%h lat=%0d",
                 sel, w ? "WR" : "RD", sz, a, wd, rd, lat);
    endtask

    logic [31:0] rd;
    logic [31:0] last_rd;
    logic [31:0] exp_b1, exp_b2;
    logic        dok_seen;
    int          acc_cyc [2];
    int          dok_cyc [2];
    logic [31:0] rd_seen [2];
    int          acc_n, dok_n;

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_v[s] = 1'b0; wr_v[s] = 1'b0; size_v[s] = 2'd2; addr_v[s] = 32'h0; wdata_v[s] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("rst_addr_ok", 32'(addr_ok_a), 32'd0);
        check("rst_data_ok", 32'(data_ok_a), 32'd0);
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);

        // Request held from reset release: accepted in the first IDLE cycle.
        rst = 1'b0;
        txn(0, 1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, rd);
        @(negedge clk);
        txn(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0, rd);
        check("wr_rd_0x10", rd, 32'hDEAD_BEEF);

        // Aliasing modulo 4 KiB
        @(negedge clk);
        txn(0, 1'b1, 2'd2, 32'h0000_1004, 32'h1234_5678, rd);
        @(negedge clk);
        txn(0, 1'b0, 2'd2, 32'h0000_0004, 32'h0, rd);
        check("alias_0x4", rd, 32'h1234_5678);

        // Byte and halfword lanes
        @(negedge clk);
        txn(0, 1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344, rd);
        @(negedge clk);
        txn(0, 1'b1, 2'd0, 32'h0000_0021, 32'h0000_AA00, rd);
        @(negedge clk);
        txn(0, 1'b0, 2'd2, 32'h0000_0020, 32'h0, rd);
`ifdef SRAM_LIKE_BYTE_WRITE_EN
        check("byte_lane", rd, 32'h1122_AA44);
`else
        check("byte_lane", rd, 32'h0000_AA00);
`endif
        @(negedge clk);
        txn(0, 1'b1, 2'd1, 32'h0000_0022, 32'h7766_0000, rd);
        @(negedge clk);
        txn(0, 1'b0, 2'd2, 32'h0000_0020, 32'h0, rd);
`ifdef SRAM_LIKE_BYTE_WRITE_EN
        check("half_lane", rd, 32'h7766_AA44);
`else
        check("half_lane", rd, 32'h7766_0000);
`endif
        last_rd = rd;

        // rdata must hold across a write response
        @(negedge clk);
        txn(0, 1'b1, 2'd2, 32'h0000_0040, 32'h55AA_55AA, rd);
        check("rdata_hold_wr", rd, last_rd);

        // Reset in WAIT discards the pending write
        @(negedge clk);
        req_v[0] = 1'b1; wr_v[0] = 1'b1; size_v[0] = 2'd2; addr_v[0] = 32'h0000_0040; wdata_v[0] = 32'hCAFE_F00D;
        #1;
        check("addr_ok_pre_rst", 32'(addr_ok_a), 32'd1);
        @(negedge clk);
        req_v[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rdata_after_rst", rdata_a, 32'h0);
        dok_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (data_ok_a) dok_seen = 1'b1;
            @(negedge clk);
        end
        check("no_dok_after_rst", 32'(dok_seen), 32'd0);
        $display("[TB] dut0 RST-in-WAIT addr=00000040 wdata=cafef00d data_ok_seen=%0d", dok_seen);
        txn(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0, rd);
        check("rst_discard_0x40", rd, 32'h55AA_55AA);

        // LATENCY = 1 instance: preload, then two back-to-back reads with req held
        exp_b1 = 32'hA1B2_C3D4;
        exp_b2 = 32'h0F0F_1E1E;
        @(negedge clk);
        txn(1, 1'b1, 2'd2, 32'h0000_0008, exp_b1, rd);
        @(negedge clk);
        txn(1, 1'b1, 2'd2, 32'h0000_000C, exp_b2, rd);
        @(negedge clk);
        req_v[1] = 1'b1; wr_v[1] = 1'b0; size_v[1] = 2'd2; addr_v[1] = 32'h0000_0008;
        #1;
        acc_n = 0; dok_n = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (addr_ok_b && acc_n < 2) begin
                acc_cyc[acc_n] = c;
                acc_n++;
            end
            if (data_ok_b && dok_n < 2) begin
                dok_cyc[dok_n] = c;
                rd_seen[dok_n] = rdata_b;
                dok_n++;
                addr_v[1] = 32'h0000_000C;
                if (dok_n == 2) req_v[1] = 1'b0;
            end
        end
        req_v[1] = 1'b0;
        check("b2b_acc_count", 32'(acc_n), 32'd2);
        check("b2b_dok_count", 32'(dok_n), 32'd2);
        if (acc_n == 2 && dok_n == 2) begin
            check("b2b_acc_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
            check("b2b_lat0", 32'(dok_cyc[0] - acc_cyc[0]), 32'd1);
            check("b2b_lat1", 32'(dok_cyc[1] - acc_cyc[1]), 32'd1);
            check("b2b_rd0", rd_seen[0], exp_b1);
            check("b2b_rd1", rd_seen[1], exp_b2);
            $display("[TB] dut1 RD-RD b2b acc=%0d,%0d dok=%0d,%0d rdata=%h,%h",
                     acc_cyc[0], acc_cyc[1], dok_cyc[0], dok_cyc[1], rd_seen[0], rd_seen[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
